codec_reg_arbiter: RTL and testbench
====================================

// Module: codec_reg_arbiter
// PURPOSE
//   Shares the single WM8731 I2C register-write engine between two requesters:
//   port 0 = boot-time codec configuration sequencer, port 1 = runtime control
//   (volume/mute from user keys). Latches one 7b addr + 9b data word, drives the
//   engine handshake, reports done or timeout error to the owning port.
//   Sits between the requesters and the I2C master, in the audio-player control path.
// PARAMETERS
//   TIMEOUT_CYC  65535  max cycles a grant may stay in ISSUE+WAIT_DONE before abort
//   CNT_W        16     timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYC
// PORTS
//   i_clk          in   1   system clock; all logic on posedge i_clk
//   i_rst          in   1   synchronous, active-high reset
//   i_init_lock    in   1   1 = only port 0 may be granted (codec not yet configured)
//   i_req0_valid   in   1   port 0 write request; held until o_req0_ready
//   i_req0_addr    in   7   port 0 codec register address
//   i_req0_data    in   9   port 0 codec register data
//   o_req0_ready   out  1   1-cycle pulse: request latched
//   o_req0_done    out  1   1-cycle pulse: write completed on bus
//   o_req0_err     out  1   1-cycle pulse: write aborted by timeout
//   i_req1_*/o_req1_*       identical set for port 1
//   o_i2c_enb      out  1   start/hold request to I2C master
//   o_addr         out  7   register address to I2C master
//   o_data         out  9   register data to I2C master
//   i_i2c_next     in   1   master has taken current word
//   i_i2c_done     in   1   master finished transaction, bus idle
//   o_i2c_abort    out  1   1-cycle pulse on timeout; master returns to idle
//   o_busy         out  1   1 whenever state != IDLE
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, owner=0, last_grant=1 (port 0 wins first), counter 0.
//   States: IDLE -> ISSUE -> WAIT_DONE -> IDLE; any ISSUE/WAIT_DONE -> IDLE on timeout.
//   IDLE: eligible = valid0 | (valid1 & !i_init_lock). Arbitration:
//     - i_init_lock=1: only port 0 considered; port 1 valid held pending, never dropped.
//     - both eligible: grant port != last_grant (round-robin); one eligible: grant it.
//     - on grant at edge n: o_addr/o_data latched, owner set, last_grant=owner,
//       o_reqX_ready=1 and o_i2c_enb=1 for cycle n+1, state ISSUE, counter cleared.
//   Requester rule: valid held until ready; drop valid in the cycle after ready.
//     Valid seen after ready is ignored (state is no longer IDLE).
//   ISSUE: o_i2c_enb=1, o_addr/o_data stable. i_i2c_next -> o_i2c_enb=0 next cycle,
//     state WAIT_DONE. i_i2c_next and i_i2c_done together -> complete directly (as below).
//   WAIT_DONE: i_i2c_done -> o_reqX_done pulse to owner, state IDLE.
//     i_i2c_done/i_i2c_next outside ISSUE/WAIT_DONE: ignored.
//   Timeout: counter increments every cycle in ISSUE/WAIT_DONE; at TIMEOUT_CYC-1 without
//     completion -> o_i2c_enb=0, o_i2c_abort + o_reqX_err pulse to owner, state IDLE.
//     Completion in the same cycle as expiry wins: done, no err.
//   Earliest re-grant: the cycle after return to IDLE (IDLE lasts >=1 cycle).
//   i_init_lock rising mid-transfer: current grant completes; gating applies at next IDLE.
//   o_addr/o_data hold last value in IDLE (no glitching to 0).
//   i_rst mid-operation: all returns to reset values at that edge; no done/err is issued
//     for the killed write.
// STRUCTURE
//   pkg: typedef enum arb_states_t {ARB_IDLE, ARB_ISSUE, ARB_WAIT_DONE};
//     localparams REG_ADDR_W=7, REG_DATA_W=9 shared with the config sequencer.
//   Sub-module arb_timeout_ctr (clear, enable, expired flag, TIMEOUT_CYC/CNT_W params).
//   The rest is one flat module: state register, arbitration comb block, output registers.
// TESTING
//   1 Port0 valid addr=0x07 data=0x00A; master gives next at +3 and done at +10
//     -> ready0 at +1, enb high 2 cycles, addr/data match, done0 one pulse, busy low after.
//   2 Both valid same cycle, lock=0, after reset -> port0 granted first, port1 granted the
//     cycle after IDLE is re-entered; third back-to-back pair grants port1 then port0 (RR).
//   3 lock=1, port1 valid held 100 cycles -> no ready1; drop lock -> ready1 within 2 cycles.
//   4 TIMEOUT_CYC=20, master never answers -> at 20 cycles from ready: abort+err0 pulses,
//     enb=0, no done0; next request is accepted normally.
//   5 next and done in same cycle during ISSUE -> done pulse to owner, no WAIT_DONE visit.
//   6 i_rst asserted during WAIT_DONE -> all outputs 0 next edge, no done/err pulse emitted.

Source files
------------

// File: rtl/codec_reg_arbiter_pkg.sv
// codec_reg_arbiter_pkg
//   Shared definitions for the WM8731 register-write arbiter. The register word
//   widths are also used by the boot-time codec configuration sequencer, so they
//   live here rather than in the arbiter itself.
//   Contents:
//     REG_ADDR_W    codec register address width (7)
//     REG_DATA_W    codec register data width (9)
//     arb_states_t  arbiter FSM states

package codec_reg_arbiter_pkg;

  localparam int REG_ADDR_W = 7;
  localparam int REG_DATA_W = 9;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_ISSUE     = 2'd1,
    ARB_WAIT_DONE = 2'd2
  } arb_states_t;

endpackage

// File: rtl/codec_reg_arbiter_if.sv
// codec_reg_arbiter_if
//   Bundles the two requester ports and the I2C register-write engine handshake
//   that the arbiter sits between.
//   Modports:
//     slave  - the arbiter: takes requests and engine status, drives grants,
//              completion pulses and the engine command word
//     master - the surroundings (requesters + I2C master)
//   Signals:
//     i_init_lock                      only port 0 may be granted
//     i_reqN_valid/addr/data           port N write request (N = 0, 1)
//     o_reqN_ready/done/err            port N latched / completed / timed-out pulses
//     o_i2c_enb, o_addr, o_data        command word to the I2C master
//     i_i2c_next, i_i2c_done           I2C master progress
//     o_i2c_abort                      timeout abort pulse to the I2C master
//     o_busy                           arbiter not idle

interface codec_reg_arbiter_if;

  logic                                        i_init_lock;

  logic                                        i_req0_valid;
  logic [codec_reg_arbiter_pkg::REG_ADDR_W-1:0] i_req0_addr;
  logic [codec_reg_arbiter_pkg::REG_DATA_W-1:0] i_req0_data;
  logic                                        o_req0_ready;
  logic                                        o_req0_done;
  logic                                        o_req0_err;

  logic                                        i_req1_valid;
  logic [codec_reg_arbiter_pkg::REG_ADDR_W-1:0] i_req1_addr;
  logic [codec_reg_arbiter_pkg::REG_DATA_W-1:0] i_req1_data;
  logic                                        o_req1_ready;
  logic                                        o_req1_done;
  logic                                        o_req1_err;

  logic                                        o_i2c_enb;
  logic [codec_reg_arbiter_pkg::REG_ADDR_W-1:0] o_addr;
  logic [codec_reg_arbiter_pkg::REG_DATA_W-1:0] o_data;
  logic                                        i_i2c_next;
  logic                                        i_i2c_done;
  logic                                        o_i2c_abort;
  logic                                        o_busy;

  modport slave (
    input  i_init_lock,
    input  i_req0_valid, i_req0_addr, i_req0_data,
    output o_req0_ready, o_req0_done, o_req0_err,
    input  i_req1_valid, i_req1_addr, i_req1_data,
    output o_req1_ready, o_req1_done, o_req1_err,
    output o_i2c_enb, o_addr, o_data, o_i2c_abort, o_busy,
    input  i_i2c_next, i_i2c_done
  );

  modport master (
    output i_init_lock,
    output i_req0_valid, i_req0_addr, i_req0_data,
    input  o_req0_ready, o_req0_done, o_req0_err,
    output i_req1_valid, i_req1_addr, i_req1_data,
    input  o_req1_ready, o_req1_done, o_req1_err,
    input  o_i2c_enb, o_addr, o_data, o_i2c_abort, o_busy,
    output i_i2c_next, i_i2c_done
  );

endinterface

// File: rtl/arb_timeout_ctr.sv
// arb_timeout_ctr
//   Cycle counter guarding one arbiter grant. Held at zero while cleared, counts
//   while enabled, and flags expiry in the cycle the count reaches TIMEOUT_CYC-1.
//   Ports:
//     clk_i      clock
//     rst_i      synchronous active-high reset
//     clear_i    force count to zero
//     enable_i   count this cycle
//     expired_o  count has reached TIMEOUT_CYC-1 while enabled
//   Parameters:
//     TIMEOUT_CYC  cycles before expiry; CNT_W must satisfy 2**CNT_W > TIMEOUT_CYC

module arb_timeout_ctr #(
  parameter int TIMEOUT_CYC = 65535,
  parameter int CNT_W       = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LastCount = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Expiry is only meaningful while the arbiter owns the engine.
  assign expired_o = enable_i && (cnt_q == LastCount);

  // Next count: clear wins, then count up, but stop at the expiry value so the
  // counter never wraps if the owner is slow to react.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/codec_reg_arbiter.sv
// codec_reg_arbiter
//   Shares the single WM8731 I2C register-write engine between the boot-time
//   configuration sequencer (port 0) and the runtime volume/mute control
//   (port 1). One 7-bit address + 9-bit data word is latched per grant, handed
//   to the engine, and the outcome (done or timeout error) is pulsed back to
//   whichever port owns the grant.
//   Ports:
//     i_clk   clock
//     i_rst   synchronous active-high reset
//     bus     codec_reg_arbiter_if.slave (requesters + I2C engine handshake)
//   Parameters:
//     TIMEOUT_CYC  maximum cycles a grant may spend in ISSUE + WAIT_DONE
//     CNT_W        timeout counter width

module codec_reg_arbiter
  import codec_reg_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = 65535,
  parameter int CNT_W       = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  codec_reg_arbiter_if.slave   bus
);

  arb_states_t           state_q;
  logic                  owner_q;
  logic                  lastGrant_q;
  logic [REG_ADDR_W-1:0] addr_q;
  logic [REG_DATA_W-1:0] data_q;
  logic                  enb_q;
  logic                  abort_q;
  logic                  ready0_q, ready1_q;
  logic                  done0_q, done1_q;
  logic                  err0_q, err1_q;

  logic                  elig0, elig1;
  logic                  grantAny;
  logic                  grantSel;
  logic                  timerClear;
  logic                  timerEnable;
  logic                  timerExpired;

  // The timeout counter sits at zero whenever the arbiter is idle, so it is
  // implicitly cleared at the grant edge and starts counting from there.
  assign timerClear  = (state_q == ARB_IDLE);
  assign timerEnable = (state_q != ARB_IDLE);

  arb_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_timeout (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .clear_i   (timerClear),
    .enable_i  (timerEnable),
    .expired_o (timerExpired)
  );

  // Arbitration. While the codec is still being configured, port 1 is masked
  // out but its valid is simply left pending. With both ports eligible the one
  // that did not win last time gets the engine.
  always_comb begin
    elig0    = bus.i_req0_valid;
    elig1    = bus.i_req1_valid && !bus.i_init_lock;
    grantAny = elig0 || elig1;
    grantSel = 1'b0;
    if (elig0 && elig1) begin
      grantSel = ~lastGrant_q;
    end else begin
      grantSel = elig1;
    end
  end

  // Arbiter FSM with all outputs registered. ready/done/err/abort are one-cycle
  // pulses, so they default low every cycle. Completion is checked before
  // expiry so a done arriving on the last allowed cycle still counts as done.
  // The address/data registers are only loaded on a grant so the engine sees a
  // stable word that also holds while idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      addr_q      <= '0;
      data_q      <= '0;
      enb_q       <= 1'b0;
      abort_q     <= 1'b0;
      ready0_q    <= 1'b0;
      ready1_q    <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
    end else begin
      ready0_q <= 1'b0;
      ready1_q <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      abort_q  <= 1'b0;

      unique case (state_q)
        ARB_IDLE: begin
          if (grantAny) begin
            owner_q     <= grantSel;
            lastGrant_q <= grantSel;
            addr_q      <= grantSel ? bus.i_req1_addr : bus.i_req0_addr;
            data_q      <= grantSel ? bus.i_req1_data : bus.i_req0_data;
            ready0_q    <= ~grantSel;
            ready1_q    <= grantSel;
            enb_q       <= 1'b1;
            state_q     <= ARB_ISSUE;
          end
        end

        ARB_ISSUE: begin
          if (bus.i_i2c_next && bus.i_i2c_done) begin
            enb_q   <= 1'b0;
            done0_q <= ~owner_q;
            done1_q <= owner_q;
            state_q <= ARB_IDLE;
          end else if (timerExpired) begin
            enb_q   <= 1'b0;
            abort_q <= 1'b1;
            err0_q  <= ~owner_q;
            err1_q  <= owner_q;
            state_q <= ARB_IDLE;
          end else if (bus.i_i2c_next) begin
            enb_q   <= 1'b0;
            state_q <= ARB_WAIT_DONE;
          end
        end

        ARB_WAIT_DONE: begin
          if (bus.i_i2c_done) begin
            done0_q <= ~owner_q;
            done1_q <= owner_q;
            state_q <= ARB_IDLE;
          end else if (timerExpired) begin
            enb_q   <= 1'b0;
            abort_q <= 1'b1;
            err0_q  <= ~owner_q;
            err1_q  <= owner_q;
            state_q <= ARB_IDLE;
          end
        end

        default: begin
          enb_q   <= 1'b0;
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  // Drive the interface from the output registers.
  assign bus.o_req0_ready = ready0_q;
  assign bus.o_req0_done  = done0_q;
  assign bus.o_req0_err   = err0_q;
  assign bus.o_req1_ready = ready1_q;
  assign bus.o_req1_done  = done1_q;
  assign bus.o_req1_err   = err1_q;
  assign bus.o_i2c_enb    = enb_q;
  assign bus.o_addr       = addr_q;
  assign bus.o_data       = data_q;
  assign bus.o_i2c_abort  = abort_q;
  assign bus.o_busy       = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_codec_reg_arbiter.sv
// tb_codec_reg_arbiter
//   Directed bench for codec_reg_arbiter: single write, round-robin sharing,
//   init-lock gating, timeout abort, next+done collapse and mid-write reset.
//   The DUT is built with a short timeout (20 cycles) so the abort path is
//   reachable quickly.

module tb_codec_reg_arbiter;

  localparam int TbTimeout = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errCount   = 0;
  int   checkCount = 0;

  codec_reg_arbiter_if bus ();

  codec_reg_arbiter #(
    .TIMEOUT_CYC (TbTimeout),
    .CNT_W       (16)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  // Safety net in case the design wedges the simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Advance one clock and settle just after the edge; inputs driven after this
  // are seen at the next edge, outputs read after this reflect the edge passed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive both request ports in one go.
  task automatic applyStimulus(input logic v0, input logic [6:0] a0, input logic [8:0] d0,
                               input logic v1, input logic [6:0] a1, input logic [8:0] d1);
    bus.i_req0_valid = v0;
    bus.i_req0_addr  = a0;
    bus.i_req0_data  = d0;
    bus.i_req1_valid = v1;
    bus.i_req1_addr  = a1;
    bus.i_req1_data  = d1;
  endtask

  task automatic setI2c(input logic nxt, input logic dn);
    bus.i_i2c_next = nxt;
    bus.i_i2c_done = dn;
  endtask

  // Reset values: everything low, including the held address/data word.
  task automatic test_reset();
    logic [8:0] flags;
    rst = 1'b1;
    bus.i_init_lock = 1'b0;
    applyStimulus(1'b0, 7'h00, 9'h000, 1'b0, 7'h00, 9'h000);
    setI2c(1'b0, 1'b0);
    tick();
    tick();
    flags = {bus.o_req0_ready, bus.o_req1_ready, bus.o_req0_done, bus.o_req1_done,
             bus.o_req0_err, bus.o_req1_err, bus.o_i2c_enb, bus.o_i2c_abort, bus.o_busy};
    checkCount++;
    if (flags !== 9'b0) begin
      errCount++;
      $display("[TB] FAIL reset_flags got=%b exp=000000000", flags);
    end
    checkCount++;
    if ({bus.o_addr, bus.o_data} !== 16'h0000) begin
      errCount++;
      $display("[TB] FAIL reset_word got=%h/%h exp=00/000", bus.o_addr, bus.o_data);
    end
    rst = 1'b0;
    tick();
  endtask

  // Port 0 write; engine takes the word two cycles into ISSUE and finishes later.
  task automatic test_single_write();
    logic sawEarly;
    applyStimulus(1'b1, 7'h07, 9'h00A, 1'b0, 7'h00, 9'h000);
    tick();
    checkCount++;
    if ({bus.o_req0_ready, bus.o_req1_ready, bus.o_i2c_enb, bus.o_busy} !== 4'b1011) begin
      errCount++;
      $display("[TB] FAIL single_grant rdy0/rdy1/enb/busy got=%b exp=1011",
               {bus.o_req0_ready, bus.o_req1_ready, bus.o_i2c_enb, bus.o_busy});
    end
    checkCount++;
    if (bus.o_addr !== 7'h07 || bus.o_data !== 9'h00A) begin
      errCount++;
      $display("[TB] FAIL single_word got=%h/%h exp=07/00a", bus.o_addr, bus.o_data);
    end
    applyStimulus(1'b0, 7'h00, 9'h000, 1'b0, 7'h00, 9'h000);
    tick();
    checkCount++;
    if ({bus.o_req0_ready, bus.o_i2c_enb} !== 2'b01) begin
      errCount++;
      $display("[TB] FAIL single_hold rdy0/enb got=%b exp=01", {bus.o_req0_ready, bus.o_i2c_enb});
    end
    setI2c(1'b1, 1'b0);
    tick();
    setI2c(1'b0, 1'b0);
    checkCount++;
    if ({bus.o_i2c_enb, bus.o_busy} !== 2'b01) begin
      errCount++;
      $display("[TB] FAIL single_next enb/busy got=%b exp=01", {bus.o_i2c_enb, bus.o_busy});
    end
    sawEarly = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.o_req0_done || bus.o_req0_err || !bus.o_busy) sawEarly = 1'b1;
    end
    checkCount++;
    if (sawEarly !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL single_wait early done/err/idle got=%b exp=0", sawEarly);
    end
    setI2c(1'b0, 1'b1);
    tick();
    setI2c(1'b0, 1'b0);
    checkCount++;
    if ({bus.o_req0_done, bus.o_req1_done, bus.o_busy} !== 3'b100) begin
      errCount++;
      $display("[TB] FAIL single_done done0/done1/busy got=%b exp=100",
               {bus.o_req0_done, bus.o_req1_done, bus.o_busy});
    end
    tick();
    checkCount++;
    if (bus.o_req0_done !== 1'b0 || bus.o_addr !== 7'h07 || bus.o_data !== 9'h00A) begin
      errCount++;
      $display("[TB] FAIL single_after done0=%b word=%h/%h exp=0 07/00a",
               bus.o_req0_done, bus.o_addr, bus.o_data);
    end
  endtask

  // Round robin: after reset port 0 wins, port 1 follows once IDLE is re-entered.
  // A lone port 0 write then leaves last grant at 0, so the next pair goes 1, 0.
  task automatic test_round_robin();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 7'h04, 9'h155, 1'b1, 7'h05, 9'h0AA);
    tick();
    checkCount++;
    if ({bus.o_req0_ready, bus.o_req1_ready} !== 2'b10 || bus.o_addr !== 7'h04) begin
      errCount++;
      $display("[TB] FAIL rr_first rdy0/rdy1=%b addr=%h exp=10 04",
               {bus.o_req0_ready, bus.o_req1_ready}, bus.o_addr);
    end
    bus.i_req0_valid = 1'b0;
    setI2c(1'b1, 1'b1);
    tick();
    setI2c(1'b0, 1'b0);
    checkCount++;
    if ({bus.o_req0_done, bus.o_req1_ready, bus.o_busy} !== 3'b100) begin
      errCount++;
      $display("[TB] FAIL rr_done0 done0/rdy1/busy got=%b exp=100",
               {bus.o_req0_done, bus.o_req1_ready, bus.o_busy});
    end
    tick();
    checkCount++;
    if (bus.o_req1_ready !== 1'b1 || bus.o_addr !== 7'h05 || bus.o_data !== 9'h0AA) begin
      errCount++;
      $display("[TB] FAIL rr_second rdy1=%b word=%h/%h exp=1 05/0aa",
               bus.o_req1_ready, bus.o_addr, bus.o_data);
    end
    bus.i_req1_valid = 1'b0;
    setI2c(1'b1, 1'b1);
    tick();
    setI2c(1'b0, 1'b0);
    checkCount++;
    if ({bus.o_req1_done, bus.o_req0_done} !== 2'b10) begin
      errCount++;
      $display("[TB] FAIL rr_done1 done1/done0 got=%b exp=10", {bus.o_req1_done, bus.o_req0_done});
    end
    applyStimulus(1'b1, 7'h01, 9'h001, 1'b0, 7'h00, 9'h000);
    tick();
    bus.i_req0_valid = 1'b0;
    setI2c(1'b1, 1'b1);
    tick();
    setI2c(1'b0, 1'b0);
    applyStimulus(1'b1, 7'h02, 9'h002, 1'b1, 7'h03, 9'h003);
    tick();
    checkCount++;
    if ({bus.o_req0_ready, bus.o_req1_ready} !== 2'b01 || bus.o_addr !== 7'h03) begin
      errCount++;
      $display("[TB] FAIL rr_third_a rdy0/rdy1=%b addr=%h exp=01 03",
               {bus.o_req0_ready, bus.o_req1_ready}, bus.o_addr);
    end
    bus.i_req1_valid = 1'b0;
    setI2c(1'b1, 1'b1);
    tick();
    setI2c(1'b0, 1'b0);
    tick();
    checkCount++;
    if ({bus.o_req0_ready, bus.o_req1_ready} !== 2'b10 || bus.o_addr !== 7'h02) begin
      errCount++;
      $display("[TB] FAIL rr_third_b rdy0/rdy1=%b addr=%h exp=10 02",
               {bus.o_req0_ready, bus.o_req1_ready}, bus.o_addr);
    end
    bus.i_req0_valid = 1'b0;
    setI2c(1'b1, 1'b1);
    tick();
    setI2c(1'b0, 1'b0);
    tick();
  endtask

  // Init lock: only port 0 may win; port 1 stays pending until the lock drops.
  task automatic test_init_lock();
    logic sawGrant;
    logic seen;
    bus.i_init_lock = 1'b1;
    applyStimulus(1'b1, 7'h0F, 9'h000, 1'b1, 7'h06, 9'h010);
    tick();
    checkCount++;
    if ({bus.o_req0_ready, bus.o_req1_ready} !== 2'b10) begin
      errCount++;
      $display("[TB] FAIL lock_port0 rdy0/rdy1 got=%b exp=10", {bus.o_req0_ready, bus.o_req1_ready});
    end
    bus.i_req0_valid = 1'b0;
    setI2c(1'b1, 1'b1);
    tick();
    setI2c(1'b0, 1'b0);
    sawGrant = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.o_req1_ready || bus.o_busy) sawGrant = 1'b1;
    end
    checkCount++;
    if (sawGrant !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL lock_hold port1 granted under lock got=%b exp=0", sawGrant);
    end
    bus.i_init_lock = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (!seen) begin
        tick();
        if (bus.o_req1_ready) seen = 1'b1;
      end
    end
    checkCount++;
    if (seen !== 1'b1 || bus.o_addr !== 7'h06 || bus.o_data !== 9'h010) begin
      errCount++;
      $display("[TB] FAIL lock_release rdy1_seen=%b word=%h/%h exp=1 06/010",
               seen, bus.o_addr, bus.o_data);
    end
    bus.i_req1_valid = 1'b0;
    setI2c(1'b1, 1'b1);
    tick();
    setI2c(1'b0, 1'b0);
    tick();
  endtask

  // Engine never answers: abort + err after exactly TbTimeout cycles from ready.
  task automatic test_timeout();
    logic sawEarly;
    applyStimulus(1'b1, 7'h08, 9'h1FF, 1'b0, 7'h00, 9'h000);
    tick();
    checkCount++;
    if (bus.o_req0_ready !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL to_grant rdy0 got=%b exp=1", bus.o_req0_ready);
    end
    bus.i_req0_valid = 1'b0;
    sawEarly = 1'b0;
    for (int i = 1; i < TbTimeout; i++) begin
      tick();
      if (bus.o_i2c_abort || bus.o_req0_err || bus.o_req0_done || !bus.o_i2c_enb) sawEarly = 1'b1;
    end
    checkCount++;
    if (sawEarly !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL to_early abort/err/done/enb-drop got=%b exp=0", sawEarly);
    end
    tick();
    checkCount++;
    if ({bus.o_i2c_abort, bus.o_req0_err, bus.o_req1_err, bus.o_req0_done, bus.o_i2c_enb, bus.o_busy}
        !== 6'b110000) begin
      errCount++;
      $display("[TB] FAIL to_expire abort/err0/err1/done0/enb/busy got=%b exp=110000",
               {bus.o_i2c_abort, bus.o_req0_err, bus.o_req1_err, bus.o_req0_done,
                bus.o_i2c_enb, bus.o_busy});
    end
    tick();
    checkCount++;
    if ({bus.o_i2c_abort, bus.o_req0_err} !== 2'b00) begin
      errCount++;
      $display("[TB] FAIL to_pulse abort/err0 got=%b exp=00", {bus.o_i2c_abort, bus.o_req0_err});
    end
    applyStimulus(1'b0, 7'h00, 9'h000, 1'b1, 7'h09, 9'h001);
    tick();
    checkCount++;
    if (bus.o_req1_ready !== 1'b1 || bus.o_addr !== 7'h09) begin
      errCount++;
      $display("[TB] FAIL to_recover rdy1=%b addr=%h exp=1 09", bus.o_req1_ready, bus.o_addr);
    end
    bus.i_req1_valid = 1'b0;
    setI2c(1'b1, 1'b1);
    tick();
    setI2c(1'b0, 1'b0);
    checkCount++;
    if ({bus.o_req1_done, bus.o_req1_err} !== 2'b10) begin
      errCount++;
      $display("[TB] FAIL to_recover_done done1/err1 got=%b exp=10", {bus.o_req1_done, bus.o_req1_err});
    end
    tick();
  endtask

  // next and done together in ISSUE finish the write straight away.
  task automatic test_next_done_same();
    applyStimulus(1'b0, 7'h00, 9'h000, 1'b1, 7'h0A, 9'h0C3);
    tick();
    bus.i_req1_valid = 1'b0;
    setI2c(1'b1, 1'b1);
    tick();
    setI2c(1'b0, 1'b0);
    checkCount++;
    if ({bus.o_req1_done, bus.o_req0_done, bus.o_i2c_enb, bus.o_busy} !== 4'b1000) begin
      errCount++;
      $display("[TB] FAIL nd_same done1/done0/enb/busy got=%b exp=1000",
               {bus.o_req1_done, bus.o_req0_done, bus.o_i2c_enb, bus.o_busy});
    end
    tick();
    checkCount++;
    if ({bus.o_req1_done, bus.o_busy} !== 2'b00) begin
      errCount++;
      $display("[TB] FAIL nd_after done1/busy got=%b exp=00", {bus.o_req1_done, bus.o_busy});
    end
  endtask

  // Reset in WAIT_DONE kills the write silently; a late done is ignored.
  task automatic test_reset_mid();
    logic [8:0] flags;
    applyStimulus(1'b1, 7'h02, 9'h017, 1'b0, 7'h00, 9'h000);
    tick();
    bus.i_req0_valid = 1'b0;
    setI2c(1'b1, 1'b0);
    tick();
    setI2c(1'b0, 1'b0);
    checkCount++;
    if ({bus.o_busy, bus.o_i2c_enb} !== 2'b10) begin
      errCount++;
      $display("[TB] FAIL rm_wait busy/enb got=%b exp=10", {bus.o_busy, bus.o_i2c_enb});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    flags = {bus.o_req0_ready, bus.o_req1_ready, bus.o_req0_done, bus.o_req1_done,
             bus.o_req0_err, bus.o_req1_err, bus.o_i2c_enb, bus.o_i2c_abort, bus.o_busy};
    checkCount++;
    if (flags !== 9'b0 || bus.o_addr !== 7'h00 || bus.o_data !== 9'h000) begin
      errCount++;
      $display("[TB] FAIL rm_reset flags=%b word=%h/%h exp=000000000 00/000",
               flags, bus.o_addr, bus.o_data);
    end
    setI2c(1'b0, 1'b1);
    tick();
    setI2c(1'b0, 1'b0);
    checkCount++;
    if ({bus.o_req0_done, bus.o_req0_err, bus.o_busy} !== 3'b000) begin
      errCount++;
      $display("[TB] FAIL rm_late_done done0/err0/busy got=%b exp=000",
               {bus.o_req0_done, bus.o_req0_err, bus.o_busy});
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    $display("[TB] start");
    test_reset();
    test_single_write();
    test_round_robin();
    test_init_lock();
    test_timeout();
    test_next_done_same();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
